htif_mem_bridge: RTL and testbench

- Host-side (HTIF/debug) burst access bridge that sits directly upstream of the shared async-read byte memory.
- Converts valid/ready request, write-data and response channels into the memory's host write port (hw_*) and host read port (hr_*).
- Used by the test harness to load program images and read back results while the core runs.
- Supports multi-beat bursts with an incrementing word address.

---
 rtl/htif_mem_pkg.sv | 25 ++
 rtl/htif_mem_bridge.sv | 247 ++++++++++++++++++++++++
 tb/tb_htif_mem_bridge.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/htif_mem_pkg.sv
// -----------------------------------------------------------------------------
// htif_mem_pkg
// Shared types and constants for the HTIF host-side memory burst bridge.
//   htifStateE     : bridge FSM states (IDLE/WR/WACK/RD/RDRAIN)
//   RW_READ/RW_WRITE : encodings of the request direction bit
//   bytesPerBeat() : number of bytes moved by one data beat
// -----------------------------------------------------------------------------
package htif_mem_pkg;

   typedef enum logic [2:0] {
      IDLE,
      WR,
      WACK,
      RD,
      RDRAIN
   } htifStateE;

   localparam logic RW_READ  = 1'b0;
   localparam logic RW_WRITE = 1'b1;

   function automatic int bytesPerBeat(input int dataWidth);
      return dataWidth / 8;
   endfunction

endpackage

// File: rtl/htif_mem_bridge.sv
// -----------------------------------------------------------------------------
// htif_mem_bridge
// Host (HTIF/debug) burst bridge in front of the shared async-read byte memory.
// Turns request / write-data / response valid-ready channels into the memory's
// host write port (hw_*) and host read port (hr_*). Bursts of req_len+1 beats
// use an incrementing address that wraps modulo the memory size.
//
// Ports:
//   clk, reset                 single clock, synchronous active-high reset
//   req_valid/ready/rw/addr/len burst request channel (rw: 0 read, 1 write)
//   wd_valid/ready/data/mask   write beat channel
//   rsp_valid/ready/data/last/err response channel (one ack per write burst,
//                              one response per beat for reads)
//   hw_addr/data/mask/en       registered memory write port, one-cycle strobe
//   hr_addr / hr_data          memory read port, hr_data combinational
//
// Build option:
//   HTIF_MEM_BRIDGE_ALIGN_CHECK_EN  when defined, a request whose start address
//   is not beat aligned touches no memory and answers with rsp_err=1.
// -----------------------------------------------------------------------------
module htif_mem_bridge
   import htif_mem_pkg::*;
#(
   parameter int  NUM_BYTES      = 1 << 21,
   parameter int  DATA_WIDTH     = 32,
   parameter int  LEN_WIDTH      = 8,
   localparam int ADDR_WIDTH     = $clog2(NUM_BYTES),
   localparam int BYTES_PER_BEAT = bytesPerBeat(DATA_WIDTH)
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      req_valid,
   output logic                      req_ready,
   input  logic                      req_rw,
   input  logic [ADDR_WIDTH-1:0]     req_addr,
   input  logic [LEN_WIDTH-1:0]      req_len,
   input  logic                      wd_valid,
   output logic                      wd_ready,
   input  logic [DATA_WIDTH-1:0]     wd_data,
   input  logic [DATA_WIDTH/8-1:0]   wd_mask,
   output logic                      rsp_valid,
   input  logic                      rsp_ready,
   output logic [DATA_WIDTH-1:0]     rsp_data,
   output logic                      rsp_last,
   output logic                      rsp_err,
   output logic [ADDR_WIDTH-1:0]     hw_addr,
   output logic [DATA_WIDTH-1:0]     hw_data,
   output logic [DATA_WIDTH/8-1:0]   hw_mask,
   output logic                      hw_en,
   output logic [ADDR_WIDTH-1:0]     hr_addr,
   input  logic [DATA_WIDTH-1:0]     hr_data
);

   htifStateE                 state_q, state_d;
   logic [ADDR_WIDTH-1:0]     curAddr_q, curAddr_d;
   logic [LEN_WIDTH-1:0]      beatsLeft_q, beatsLeft_d;
   logic                      rspValid_q, rspValid_d;
   logic [DATA_WIDTH-1:0]     rspData_q, rspData_d;
   logic                      rspLast_q, rspLast_d;
   logic [ADDR_WIDTH-1:0]     hwAddr_q, hwAddr_d;
   logic [DATA_WIDTH-1:0]     hwData_q, hwData_d;
   logic [DATA_WIDTH/8-1:0]   hwMask_q, hwMask_d;
   logic                      hwEn_q, hwEn_d;
   logic                      reqAccept;
   logic                      beatAccept;

`ifdef HTIF_MEM_BRIDGE_ALIGN_CHECK_EN
   localparam int OFF_BITS = $clog2(BYTES_PER_BEAT);
   logic                      reqMisaligned;
   logic                      err_q, err_d;
   logic                      rspErr_q, rspErr_d;

   assign reqMisaligned = (req_addr[OFF_BITS-1:0] != '0);
   assign rsp_err       = rspErr_q;
`else
   assign rsp_err       = 1'b0;
`endif

   // Ready signals are gated by reset so every output reads 0 while in reset.
   assign req_ready  = (state_q == IDLE) && !reset;
   assign wd_ready   = (state_q == WR) && !reset;
   assign reqAccept  = req_valid && req_ready;
   assign beatAccept = wd_valid && wd_ready;

   // The read address follows the burst pointer only while reading, so the
   // memory read port sits at 0 otherwise.
   assign hr_addr   = (state_q == RD) ? curAddr_q : '0;

   assign rsp_valid = rspValid_q;
   assign rsp_data  = rspData_q;
   assign rsp_last  = rspLast_q;
   assign hw_addr   = hwAddr_q;
   assign hw_data   = hwData_q;
   assign hw_mask   = hwMask_q;
   assign hw_en     = hwEn_q;

   // Next-state and datapath logic. hw_en defaults low so every accepted
   // write beat produces exactly one strobe cycle. In RD a new beat is loaded
   // whenever the response register is empty or being drained this cycle,
   // which gives one beat per cycle under continuous rsp_ready.
   always_comb begin
      state_d     = state_q;
      curAddr_d   = curAddr_q;
      beatsLeft_d = beatsLeft_q;
      rspValid_d  = rspValid_q;
      rspData_d   = rspData_q;
      rspLast_d   = rspLast_q;
      hwAddr_d    = hwAddr_q;
      hwData_d    = hwData_q;
      hwMask_d    = hwMask_q;
      hwEn_d      = 1'b0;
`ifdef HTIF_MEM_BRIDGE_ALIGN_CHECK_EN
      err_d       = err_q;
      rspErr_d    = rspErr_q;
`endif

      unique case (state_q)
         IDLE: begin
            if (reqAccept) begin
               curAddr_d   = req_addr;
               beatsLeft_d = req_len;
`ifdef HTIF_MEM_BRIDGE_ALIGN_CHECK_EN
               err_d = reqMisaligned;
               if (req_rw == RW_WRITE) begin
                  state_d = WR;
               end else if (reqMisaligned) begin
                  state_d    = RDRAIN;
                  rspValid_d = 1'b1;
                  rspLast_d  = 1'b1;
                  rspData_d  = '0;
                  rspErr_d   = 1'b1;
               end else begin
                  state_d = RD;
               end
`else
               state_d = (req_rw == RW_WRITE) ? WR : RD;
`endif
            end
         end

         WR: begin
            if (beatAccept) begin
`ifdef HTIF_MEM_BRIDGE_ALIGN_CHECK_EN
               if (!err_q) begin
                  hwEn_d   = 1'b1;
                  hwAddr_d = curAddr_q;
                  hwData_d = wd_data;
                  hwMask_d = wd_mask;
               end
`else
               hwEn_d   = 1'b1;
               hwAddr_d = curAddr_q;
               hwData_d = wd_data;
               hwMask_d = wd_mask;
`endif
               curAddr_d   = curAddr_q + ADDR_WIDTH'(BYTES_PER_BEAT);
               beatsLeft_d = beatsLeft_q - LEN_WIDTH'(1);
               if (beatsLeft_q == '0) begin
                  state_d    = WACK;
                  rspValid_d = 1'b1;
                  rspLast_d  = 1'b1;
                  rspData_d  = '0;
`ifdef HTIF_MEM_BRIDGE_ALIGN_CHECK_EN
                  rspErr_d   = err_q;
`endif
               end
            end
         end

         WACK: begin
            if (rsp_ready) begin
               state_d    = IDLE;
               rspValid_d = 1'b0;
               rspLast_d  = 1'b0;
`ifdef HTIF_MEM_BRIDGE_ALIGN_CHECK_EN
               rspErr_d   = 1'b0;
`endif
            end
         end

         RD: begin
            if (!rspValid_q || rsp_ready) begin
               rspData_d   = hr_data;
               rspValid_d  = 1'b1;
               rspLast_d   = (beatsLeft_q == '0);
               curAddr_d   = curAddr_q + ADDR_WIDTH'(BYTES_PER_BEAT);
               beatsLeft_d = beatsLeft_q - LEN_WIDTH'(1);
               if (beatsLeft_q == '0) begin
                  state_d = RDRAIN;
               end
            end
         end

         RDRAIN: begin
            if (rsp_ready) begin
               state_d    = IDLE;
               rspValid_d = 1'b0;
               rspLast_d  = 1'b0;
`ifdef HTIF_MEM_BRIDGE_ALIGN_CHECK_EN
               rspErr_d   = 1'b0;
`endif
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers. Reset abandons any burst in flight: the
   // write strobe and pending response are cleared and no ack is produced.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         curAddr_q   <= '0;
         beatsLeft_q <= '0;
         rspValid_q  <= 1'b0;
         rspData_q   <= '0;
         rspLast_q   <= 1'b0;
         hwAddr_q    <= '0;
         hwData_q    <= '0;
         hwMask_q    <= '0;
         hwEn_q      <= 1'b0;
`ifdef HTIF_MEM_BRIDGE_ALIGN_CHECK_EN
         err_q       <= 1'b0;
         rspErr_q    <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         curAddr_q   <= curAddr_d;
         beatsLeft_q <= beatsLeft_d;
         rspValid_q  <= rspValid_d;
         rspData_q   <= rspData_d;
         rspLast_q   <= rspLast_d;
         hwAddr_q    <= hwAddr_d;
         hwData_q    <= hwData_d;
         hwMask_q    <= hwMask_d;
         hwEn_q      <= hwEn_d;
`ifdef HTIF_MEM_BRIDGE_ALIGN_CHECK_EN
         err_q       <= err_d;
         rspErr_q    <= rspErr_d;
`endif
      end
   end

endmodule

// File: tb/tb_htif_mem_bridge.sv
// -----------------------------------------------------------------------------
// tb_htif_mem_bridge
// Self-checking bench for htif_mem_bridge. The bench owns a word-wide memory
// that the bridge writes through hw_* and reads through hr_*, and a byte-level
// reference memory updated from the bursts it issues. Read data, acks and the
// sequence of memory write strobes are compared against that reference.
// -----------------------------------------------------------------------------
module tb_htif_mem_bridge;
   import htif_mem_pkg::*;

   localparam int NUM_BYTES  = 1 << 21;
   localparam int DATA_WIDTH = 32;
   localparam int LEN_WIDTH  = 8;
   localparam int ADDR_WIDTH = 21;
   localparam int BUDGET     = 200;

   typedef struct packed {
      logic [ADDR_WIDTH-1:0] addr;
      logic [31:0]           data;
      logic [3:0]            mask;
   } hwBeatT;

   logic                  clk;
   logic                  reset;
   logic                  req_valid;
   logic                  req_ready;
   logic                  req_rw;
   logic [ADDR_WIDTH-1:0] req_addr;
   logic [LEN_WIDTH-1:0]  req_len;
   logic                  wd_valid;
   logic                  wd_ready;
   logic [31:0]           wd_data;
   logic [3:0]            wd_mask;
   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [31:0]           rsp_data;
   logic                  rsp_last;
   logic                  rsp_err;
   logic [ADDR_WIDTH-1:0] hw_addr;
   logic [31:0]           hw_data;
   logic [3:0]            hw_mask;
   logic                  hw_en;
   logic [ADDR_WIDTH-1:0] hr_addr;
   logic [31:0]           hr_data;

   int assertCount = 0;
   int failCount   = 0;

   bit [31:0]   memW [NUM_BYTES/4];
   bit [7:0]    refMem [int];
   hwBeatT      obsQ[$];
   hwBeatT      expQ[$];
   int          obsBase = 0;
   logic [31:0] rdQ[$];
   logic [31:0] wrData [256];
   logic [3:0]  wrMask [256];

   htif_mem_bridge #(
      .NUM_BYTES (NUM_BYTES),
      .DATA_WIDTH(DATA_WIDTH),
      .LEN_WIDTH (LEN_WIDTH)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .req_valid(req_valid),
      .req_ready(req_ready),
      .req_rw   (req_rw),
      .req_addr (req_addr),
      .req_len  (req_len),
      .wd_valid (wd_valid),
      .wd_ready (wd_ready),
      .wd_data  (wd_data),
      .wd_mask  (wd_mask),
      .rsp_valid(rsp_valid),
      .rsp_ready(rsp_ready),
      .rsp_data (rsp_data),
      .rsp_last (rsp_last),
      .rsp_err  (rsp_err),
      .hw_addr  (hw_addr),
      .hw_data  (hw_data),
      .hw_mask  (hw_mask),
      .hw_en    (hw_en),
      .hr_addr  (hr_addr),
      .hr_data  (hr_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory behind the bridge: applies strobed writes and logs every strobe.
   always @(posedge clk) begin
      if (hw_en) begin
         for (int b = 0; b < 4; b++) begin
            if (hw_mask[b]) memW[hw_addr[ADDR_WIDTH-1:2]][8*b +: 8] <= hw_data[8*b +: 8];
         end
         obsQ.push_back({hw_addr, hw_data, hw_mask});
      end
   end

   assign hr_data = memW[hr_addr[ADDR_WIDTH-1:2]];

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      assertCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   function automatic logic [ADDR_WIDTH-1:0] beatAddr(input logic [ADDR_WIDTH-1:0] base, input int i);
      return base + ADDR_WIDTH'(4 * i);
   endfunction

   task automatic refWrite(input logic [ADDR_WIDTH-1:0] a, input logic [31:0] d, input logic [3:0] m);
      logic [ADDR_WIDTH-1:0] ab;
      for (int b = 0; b < 4; b++) begin
         ab = a + ADDR_WIDTH'(b);
         if (m[b]) refMem[int'(ab)] = d[8*b +: 8];
      end
   endtask

   function automatic logic [31:0] refRead(input logic [ADDR_WIDTH-1:0] a);
      logic [31:0]           w;
      logic [ADDR_WIDTH-1:0] ab;
      w = '0;
      for (int b = 0; b < 4; b++) begin
         ab = a + ADDR_WIDTH'(b);
         if (refMem.exists(int'(ab))) w[8*b +: 8] = refMem[int'(ab)];
      end
      return w;
   endfunction

   // Every task starts and ends right after a falling edge.
   task automatic sendRequest(input logic rw, input logic [ADDR_WIDTH-1:0] addr, input int len);
      int cnt;
      req_valid = 1'b1;
      req_rw    = rw;
      req_addr  = addr;
      req_len   = LEN_WIDTH'(len);
      cnt = 0;
      while (!req_ready && cnt < BUDGET) begin
         @(negedge clk);
         cnt++;
      end
      checkOutput("reqReady", req_ready, 1);
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   task automatic writeBeats(input logic [ADDR_WIDTH-1:0] addr, input int len, input int stopAfter, input logic expErr);
      int cnt;
      for (int i = 0; i <= len && i < stopAfter; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            wd_valid = 1'b0;
            @(negedge clk);
         end
         wd_valid = 1'b1;
         wd_data  = wrData[i];
         wd_mask  = wrMask[i];
         cnt = 0;
         while (!wd_ready && cnt < BUDGET) begin
            @(negedge clk);
            cnt++;
         end
         checkOutput($sformatf("wdReady%0d", i), wd_ready, 1);
         @(negedge clk);
         if (!expErr) begin
            refWrite(beatAddr(addr, i), wrData[i], wrMask[i]);
            expQ.push_back({beatAddr(addr, i), wrData[i], wrMask[i]});
         end
      end
      wd_valid = 1'b0;
   endtask

   task automatic waitWriteAck(input logic expErr);
      int cnt;
      cnt = 0;
      while (!rsp_valid && cnt < BUDGET) begin
         @(negedge clk);
         cnt++;
      end
      checkOutput("ackValid", rsp_valid, 1);
      checkOutput("ackLast", rsp_last, 1);
      checkOutput("ackData", rsp_data, 0);
      checkOutput("ackErr", rsp_err, expErr);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      checkOutput("ackHeld", rsp_valid, 1);
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      checkOutput("ackSingle", rsp_valid, 0);
      @(negedge clk);
      checkOutput("ackStillIdle", rsp_valid, 0);
   endtask

   task automatic checkHwBeats();
      int nObs;
      nObs = obsQ.size() - obsBase;
      checkOutput("hwCount", nObs, expQ.size());
      for (int i = 0; i < nObs && i < expQ.size(); i++) begin
         checkOutput($sformatf("hwBeat%0d", i), obsQ[obsBase + i], expQ[i]);
      end
      obsBase = obsQ.size();
      expQ.delete();
   endtask

   // readyMode: 0 random, 1 always ready, 2 repeating 1,0,0.
   task automatic readBurst(input logic [ADDR_WIDTH-1:0] addr, input int len, input int readyMode);
      int          rdCount;
      int          cnt;
      logic        stalled;
      logic [31:0] stallData;
      rdQ.delete();
      rdCount = 0;
      cnt     = 0;
      stalled = 1'b0;
      stallData = '0;
      while (rdCount <= len && cnt < BUDGET) begin
         if (stalled) checkOutput("stallData", rsp_data, stallData);
         case (readyMode)
            1:       rsp_ready = 1'b1;
            2:       rsp_ready = ((cnt % 3) == 0);
            default: rsp_ready = 1'($urandom_range(0, 1));
         endcase
         stalled = 1'b0;
         if (rsp_valid && rsp_ready) begin
            checkOutput($sformatf("rdData%0d", rdCount), rsp_data, refRead(beatAddr(addr, rdCount)));
            checkOutput($sformatf("rdLast%0d", rdCount), rsp_last, (rdCount == len));
            rdQ.push_back(rsp_data);
            rdCount++;
         end else if (rsp_valid) begin
            stalled   = 1'b1;
            stallData = rsp_data;
         end
         @(negedge clk);
         cnt++;
      end
      rsp_ready = 1'b0;
      checkOutput("rdBeats", rdCount, len + 1);
      checkOutput("rdDone", rsp_valid, 0);
   endtask

   task automatic applyStimulus(input logic rw, input logic [ADDR_WIDTH-1:0] addr, input int len, input int readyMode);
      sendRequest(rw, addr, len);
      if (rw == RW_WRITE) begin
         writeBeats(addr, len, len + 1, 1'b0);
         waitWriteAck(1'b0);
         checkHwBeats();
      end else begin
         readBurst(addr, len, readyMode);
      end
   endtask

   initial begin
      logic [ADDR_WIDTH-1:0] a;
      int                    l;

      reset     = 1'b1;
      req_valid = 1'b0;
      req_rw    = 1'b0;
      req_addr  = '0;
      req_len   = '0;
      wd_valid  = 1'b0;
      wd_data   = '0;
      wd_mask   = '0;
      rsp_ready = 1'b0;
      repeat (3) @(negedge clk);

      checkOutput("rstOutputs",
                  {req_ready, wd_ready, rsp_valid, rsp_data, rsp_last, rsp_err,
                   hw_en, hw_mask, hw_data, hw_addr, hr_addr}, '0);
      reset = 1'b0;
      @(negedge clk);
      checkOutput("idleReqReady", req_ready, 1);

      // Four-word burst written then read back.
      $display("[TB] directed write/read burst at 0x100");
      for (int i = 0; i < 4; i++) begin
         wrData[i] = 32'h11111111 * (i + 1);
         wrMask[i] = 4'hF;
      end
      applyStimulus(RW_WRITE, 21'h100, 3, 1);
      applyStimulus(RW_READ, 21'h100, 3, 1);
      for (int i = 0; i < 4; i++) begin
         checkOutput($sformatf("dirWord%0d", i), rdQ[i], 32'h11111111 * (i + 1));
      end

      // Partial byte mask over untouched (zero) memory.
      $display("[TB] partial mask write at 0x200");
      wrData[0] = 32'hAABBCCDD;
      wrMask[0] = 4'h5;
      applyStimulus(RW_WRITE, 21'h200, 0, 1);
      applyStimulus(RW_READ, 21'h200, 0, 1);
      checkOutput("partialMask", rdQ[0], 32'h00BB00DD);

      // All-zero mask still strobes the write port but changes nothing.
      wrData[0] = 32'hDEADBEEF;
      wrMask[0] = 4'h0;
      applyStimulus(RW_WRITE, 21'h200, 0, 1);
      applyStimulus(RW_READ, 21'h200, 0, 1);
      checkOutput("zeroMask", rdQ[0], 32'h00BB00DD);

      // Response backpressure on an eight-beat read.
      $display("[TB] backpressured read of 8 beats");
      for (int i = 0; i < 8; i++) begin
         wrData[i] = $urandom;
         wrMask[i] = 4'hF;
      end
      applyStimulus(RW_WRITE, 21'h400, 7, 1);
      applyStimulus(RW_READ, 21'h400, 7, 2);

      // Burst crossing the top of memory wraps to address 0.
      $display("[TB] address wrap");
      wrData[0] = 32'hCAFEF00D;
      wrData[1] = 32'h0BADC0DE;
      wrMask[0] = 4'hF;
      wrMask[1] = 4'hF;
      applyStimulus(RW_WRITE, 21'(NUM_BYTES - 4), 1, 1);
      applyStimulus(RW_READ, 21'(NUM_BYTES - 4), 1, 0);
      checkOutput("wrapHigh", rdQ[0], 32'hCAFEF00D);
      checkOutput("wrapZero", rdQ[1], 32'h0BADC0DE);

      // Reset after two of four write beats abandons the burst.
      $display("[TB] reset mid write burst");
      for (int i = 0; i < 4; i++) begin
         wrData[i] = $urandom;
         wrMask[i] = 4'hF;
      end
      sendRequest(RW_WRITE, 21'h600, 3);
      writeBeats(21'h600, 3, 2, 1'b0);
      wd_valid = 1'b1;
      wd_data  = wrData[2];
      wd_mask  = wrMask[2];
      reset    = 1'b1;
      @(negedge clk);
      checkOutput("rstMidHwEn", hw_en, 0);
      checkOutput("rstMidRspValid", rsp_valid, 0);
      checkOutput("rstMidReqReady", req_ready, 0);
      reset    = 1'b0;
      wd_valid = 1'b0;
      @(negedge clk);
      checkOutput("postRstReqReady", req_ready, 1);
      checkOutput("postRstRspValid", rsp_valid, 0);
      checkOutput("postRstRspLast", rsp_last, 0);
      repeat (4) @(negedge clk);
      checkOutput("postRstNoAck", rsp_valid, 0);
      checkHwBeats();

`ifdef HTIF_MEM_BRIDGE_ALIGN_CHECK_EN
      // Misaligned requests touch no memory and report an error.
      $display("[TB] misaligned requests");
      begin
         int cnt;
         sendRequest(RW_READ, 21'h102, 2);
         cnt = 0;
         while (!rsp_valid && cnt < BUDGET) begin
            @(negedge clk);
            cnt++;
         end
         checkOutput("misRdValid", rsp_valid, 1);
         checkOutput("misRdErr", rsp_err, 1);
         checkOutput("misRdLast", rsp_last, 1);
         checkOutput("misRdData", rsp_data, 0);
         checkOutput("misRdAddr", hr_addr, 0);
         rsp_ready = 1'b1;
         @(negedge clk);
         rsp_ready = 1'b0;
         checkOutput("misRdSingle", rsp_valid, 0);
         checkOutput("misRdIdle", req_ready, 1);
      end
      wrData[0] = 32'h12345678;
      wrData[1] = 32'h9ABCDEF0;
      wrMask[0] = 4'hF;
      wrMask[1] = 4'hF;
      sendRequest(RW_WRITE, 21'h106, 1);
      writeBeats(21'h106, 1, 2, 1'b1);
      waitWriteAck(1'b1);
      checkHwBeats();
      applyStimulus(RW_READ, 21'h104, 1, 1);
`endif

      // Randomised bursts in a small window so reads revisit written data.
      $display("[TB] random bursts");
      for (int n = 0; n < 24; n++) begin
         a = 21'h4000 + ADDR_WIDTH'($urandom_range(0, 255) * 4);
         l = $urandom_range(0, 7);
         if ($urandom_range(0, 1) == 1) begin
            for (int i = 0; i <= l; i++) begin
               wrData[i] = $urandom;
               wrMask[i] = 4'($urandom_range(0, 15));
            end
            applyStimulus(RW_WRITE, a, l, 1);
         end else begin
            applyStimulus(RW_READ, a, l, $urandom_range(0, 2));
         end
      end

      repeat (2) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
